// File: rtl/pipelined_carry_adder.sv
// Pipelined ripple-carry adder: STAGES registered SEG-bit segments, valid/ready on both sides.
// Optional subtract mode (in_sub port) when ADDER_SUB_EN is defined.
module pipelined_carry_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef ADDER_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int SEG = WIDTH / STAGES;

  // Per-stage registers: index k is the output of stage k.
  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] r_cy;
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic [WIDTH-1:0]  r_sum [STAGES];

  // Per-stage combinational inputs and next values.
  logic [WIDTH-1:0]  w_a     [STAGES];
  logic [WIDTH-1:0]  w_b     [STAGES];
  logic [WIDTH-1:0]  w_s     [STAGES];
  logic [WIDTH-1:0]  w_s_nxt [STAGES];
  logic [SEG:0]      w_seg   [STAGES];
  logic [STAGES-1:0] w_c;
  logic [STAGES-1:0] w_c_nxt;

  logic [WIDTH-1:0]  w_b_eff;
  logic              w_cin_eff;
  logic              w_adv;

`ifdef ADDER_SUB_EN
  // Subtraction is folded into the operand at entry, so B' and the forced carry travel with it.
  assign w_b_eff   = in_sub ? ~in_b : in_b;
  assign w_cin_eff = in_sub | in_cin;
`else
  assign w_b_eff   = in_b;
  assign w_cin_eff = in_cin;
`endif

  assign w_adv    = out_ready | ~r_vld[STAGES-1];
  assign in_ready = w_adv;

  always_comb begin
    w_a[0] = in_a;
    w_b[0] = w_b_eff;
    w_s[0] = '0;
    w_c    = '0;
    w_c[0] = w_cin_eff;
    for (int k = 1; k < STAGES; k++) begin
      w_a[k] = r_a[k-1];
      w_b[k] = r_b[k-1];
      w_s[k] = r_sum[k-1];
      w_c[k] = r_cy[k-1];
    end
    w_c_nxt = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_seg[k] = {1'b0, w_a[k][k*SEG +: SEG]}
               + {1'b0, w_b[k][k*SEG +: SEG]}
               + {{SEG{1'b0}}, w_c[k]};
      w_s_nxt[k]                = w_s[k];
      w_s_nxt[k][k*SEG +: SEG]  = w_seg[k][SEG-1:0];
      w_c_nxt[k]                = w_seg[k][SEG];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_cy  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
      end
    end else if (w_adv) begin
      r_vld <= {r_vld[STAGES-1:0] << 1} | {{(STAGES-1){1'b0}}, in_valid};
      r_cy  <= w_c_nxt;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= w_a[k];
        r_b[k]   <= w_b[k];
        r_sum[k] <= w_s_nxt[k];
      end
    end
  end

  assign out_valid = r_vld[STAGES-1];
  assign out_sum   = r_sum[STAGES-1];
  assign out_cout  = r_cy[STAGES-1];
  // Final-stage skew registers still hold A and B', so overflow is decoded from registers only.
  assign out_ovf   = (r_a[STAGES-1][WIDTH-1] == r_b[STAGES-1][WIDTH-1])
                   & (r_sum[STAGES-1][WIDTH-1] != r_a[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Bench for pipelined_carry_adder (WIDTH=16, STAGES=4): directed vectors, reset flush, random stream.
module tb_pipelined_carry_adder;
  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         sub_sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  pipelined_carry_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef ADDER_SUB_EN
    .in_sub    (sub_sel),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t        vecs[$];
  logic [17:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain modulo arithmetic, result packed as {ovf, cout, sum}.
  function automatic logic [17:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic cin, input logic sub);
    logic [W:0]   full;
    logic [W-1:0] bb;
    logic         c;
    bb   = sub ? ~b : b;
    c    = sub ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
    return {(a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]), full[W], full[W-1:0]};
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    in_a     = v.a;
    in_b     = v.b;
    in_cin   = v.cin;
    sub_sel  = v.sub;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    check($sformatf("vec%0d_in_ready", idx), {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    // Accepting edge plus S-1 further edges.
    check($sformatf("vec%0d_latency", idx), lat, S - 1);
    check($sformatf("vec%0d_sum", idx), {16'd0, out_sum}, {16'd0, v.sum});
    check($sformatf("vec%0d_cout", idx), {31'd0, out_cout}, {31'd0, v.cout});
    check($sformatf("vec%0d_ovf", idx), {31'd0, out_ovf}, {31'd0, v.ovf});
    @(posedge clk); #1;
    check($sformatf("vec%0d_drain", idx), {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int stale;
    int sent;
    int rcv;
    int cyc;
    logic         stalled_prev;
    logic [W-1:0] held_sum;
    logic         held_cout;
    logic         held_ovf;
    logic [17:0]  e;

    vecs.push_back('{a:16'h0005, b:16'h0003, cin:1'b0, sub:1'b0, sum:16'h0008, cout:1'b0, ovf:1'b0});
    vecs.push_back('{a:16'hFFFF, b:16'h0001, cin:1'b0, sub:1'b0, sum:16'h0000, cout:1'b1, ovf:1'b0});
    vecs.push_back('{a:16'hFFFF, b:16'hFFFF, cin:1'b1, sub:1'b0, sum:16'hFFFF, cout:1'b1, ovf:1'b0});
    vecs.push_back('{a:16'h7FFF, b:16'h0001, cin:1'b0, sub:1'b0, sum:16'h8000, cout:1'b0, ovf:1'b1});
    vecs.push_back('{a:16'h8000, b:16'h8000, cin:1'b0, sub:1'b0, sum:16'h0000, cout:1'b1, ovf:1'b1});
`ifdef ADDER_SUB_EN
    vecs.push_back('{a:16'h0009, b:16'h0006, cin:1'b0, sub:1'b1, sum:16'h0003, cout:1'b1, ovf:1'b0});
    vecs.push_back('{a:16'h8000, b:16'h0001, cin:1'b0, sub:1'b1, sum:16'h7FFF, cout:1'b1, ovf:1'b1});
`endif

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    sub_sel = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_sum", {16'd0, out_sum}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Reset flush with three transactions in flight, the oldest already presented.
    for (int i = 0; i < 3; i++) begin
      in_a = 16'h1111 * (i + 1); in_b = 16'h0101; in_cin = 1'b1; sub_sel = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("flush_pre_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_out_sum", {16'd0, out_sum}, 32'd0);
    check("flush_out_cout", {31'd0, out_cout}, 32'd0);
    check("flush_out_ovf", {31'd0, out_ovf}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("flush_no_stale", stale, 0);

    // Random stream with toggling out_ready.
    sent = 0; rcv = 0; cyc = 0;
    stalled_prev = 1'b0;
    held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
`ifdef ADDER_SUB_EN
    sub_sel = 1'($urandom);
`endif
    while (rcv < 8 && cyc < 300) begin
      if (stalled_prev) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_sum", {16'd0, out_sum}, {16'd0, held_sum});
        check("stall_flags", {30'd0, out_cout, out_ovf}, {30'd0, held_cout, held_ovf});
      end
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid  = (sent < 8);
      #1;
      check("stream_in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("stream%0d_sum", rcv), {16'd0, out_sum}, {16'd0, e[15:0]});
          check($sformatf("stream%0d_flags", rcv), {30'd0, out_cout, out_ovf}, {30'd0, e[16], e[17]});
        end
        rcv++;
      end
      stalled_prev = out_valid && !out_ready;
      held_sum = out_sum; held_cout = out_cout; held_ovf = out_ovf;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_a, in_b, in_cin, sub_sel));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      if (sent > 0 && !(in_valid && !in_ready)) begin
        in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
`ifdef ADDER_SUB_EN
        sub_sel = 1'($urandom);
`endif
      end
    end
    in_valid = 1'b0;
    check("stream_count", rcv, 8);
    check("stream_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
